qpi_port_arbiter: RTL and testbench

//   Shares one QPI-style memory port (do_read/do_write/addr/wdata/rdata/next_word/is_idle)

---
 rtl/qpi_arb_pkg.sv | 30 +++
 rtl/qpi_rr_pick.sv | 52 +++++
 rtl/qpi_port_arbiter.sv | 121 ++++++++++++
 tb/tb_qpi_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpi_arb_pkg.sv
// ============================================================================
// Module  : qpi_arb_pkg
// Brief   : Shared constants and state encoding for the QPI port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package qpi_arb_pkg;

  localparam int QPI_AW = 25;
  localparam int QPI_DW = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACTIVE = ST_ACTIVE,
    S_DRAIN  = ST_DRAIN
  } arb_state_e;

  // Port index width; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qpi_rr_pick.sv
// ============================================================================
// Module  : qpi_rr_pick
// Brief   : Combinational rotate-priority picker, search starts at last+1.
//           QPI_ARB_PRIO_EN: port 0 always wins, the rest rotate.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module qpi_rr_pick
  import qpi_arb_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int IW     = idx_w(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     last,
  output logic              any,
  output logic [IW-1:0]     winner
);

  logic [NPORTS-1:0] req_m;
  logic              found;
  int                idx;
  logic [IW-1:0]     pos;

  always_comb begin
    req_m  = req;
    any    = |req;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    pos    = '0;
`ifdef QPI_ARB_PRIO_EN
    req_m[0] = 1'b0;
`endif
    for (int k = 1; k <= NPORTS; k++) begin
      idx = int'(last) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      pos = idx[IW-1:0];
      if (!found && req_m[pos]) begin
        found  = 1'b1;
        winner = pos;
      end
    end
`ifdef QPI_ARB_PRIO_EN
    if (req[0]) winner = '0;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/qpi_port_arbiter.sv
// ============================================================================
// Module  : qpi_port_arbiter
// Brief   : Round-robin sharing of one QPI memory port, grant held per transfer.
//           Optional macro QPI_ARB_PRIO_EN gives port 0 fixed top priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module qpi_port_arbiter
  import qpi_arb_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int AW     = QPI_AW,
  parameter int DW     = QPI_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NPORTS-1:0]    s_do_read,
  input  logic [NPORTS-1:0]    s_do_write,
  input  logic [NPORTS*AW-1:0] s_addr,
  input  logic [NPORTS*DW-1:0] s_wdata,
  output logic [DW-1:0]        s_rdata,
  output logic [NPORTS-1:0]    s_next_word,
  output logic [NPORTS-1:0]    s_is_idle,
  output logic                 m_do_read,
  output logic                 m_do_write,
  output logic [AW-1:0]        m_addr,
  output logic [DW-1:0]        m_wdata,
  input  logic [DW-1:0]        m_rdata,
  input  logic                 m_next_word,
  input  logic                 m_is_idle
);

  localparam int            IW       = idx_w(NPORTS);
  localparam logic [IW-1:0] LAST_RST = IW'(NPORTS - 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q,  last_d;
  logic [NPORTS-1:0] req;
  logic              pick_any;
  logic [IW-1:0]     pick_winner;
  logic [AW-1:0]     addr_arr  [NPORTS];
  logic [DW-1:0]     wdata_arr [NPORTS];

  generate
    for (genvar i = 0; i < NPORTS; i++) begin : g_port
      assign req[i]       = s_do_read[i] | s_do_write[i];
      assign addr_arr[i]  = s_addr[i*AW +: AW];
      assign wdata_arr[i] = s_wdata[i*DW +: DW];
      // The owner stays busy until the arbiter is back in IDLE.
      assign s_is_idle[i] = !req[i] && !((owner_q == IW'(i)) && (state_q != S_IDLE));
    end
  endgenerate

  qpi_rr_pick #(
    .NPORTS (NPORTS),
    .IW     (IW)
  ) u_pick (
    .req    (req),
    .last   (last_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_ACTIVE;
          owner_d = pick_winner;
        end
      end
      S_ACTIVE: begin
        if (!req[owner_q]) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (m_is_idle) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_do_read   = 1'b0;
    m_do_write  = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    s_next_word = '0;
    if (state_q == S_ACTIVE) begin
      m_do_read            = s_do_read[owner_q];
      m_do_write           = s_do_write[owner_q];
      m_addr               = addr_arr[owner_q];
      m_wdata              = wdata_arr[owner_q];
      s_next_word[owner_q] = m_next_word;
    end
  end

  assign s_rdata = m_rdata;

endmodule

`default_nettype wire

// File: tb/tb_qpi_port_arbiter.sv
// ============================================================================
// Module  : tb_qpi_port_arbiter
// Brief   : Directed self-checking bench for qpi_port_arbiter (3 ports).
//           Honours QPI_ARB_PRIO_EN for the priority-dependent expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qpi_port_arbiter;

  localparam int NP = 3;
  localparam int AW = 25;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    s_do_read, s_do_write;
  logic [NP*AW-1:0] s_addr;
  logic [NP*DW-1:0] s_wdata;
  logic [DW-1:0]    s_rdata;
  logic [NP-1:0]    s_next_word, s_is_idle;
  logic             m_do_read, m_do_write;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic [DW-1:0]    m_rdata;
  logic             m_next_word, m_is_idle;

  int n_vec = 0;
  int n_err = 0;

  qpi_port_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_do_read   (s_do_read),
    .s_do_write  (s_do_write),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_rdata     (s_rdata),
    .s_next_word (s_next_word),
    .s_is_idle   (s_is_idle),
    .m_do_read   (m_do_read),
    .m_do_write  (m_do_write),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_rdata     (m_rdata),
    .m_next_word (m_next_word),
    .m_is_idle   (m_is_idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) assert ((s_do_read & s_do_write) == '0)
      else $error("illegal simultaneous read and write request");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rd(input int p, input logic v, input logic [AW-1:0] a);
    s_do_read[p]       = v;
    s_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_do_write[p]       = v;
    s_addr[p*AW +: AW]  = a;
    s_wdata[p*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    s_do_read  = '0;
    s_do_write = '0;
    s_addr     = '0;
    s_wdata    = '0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    clear_reqs();
    m_rdata     = '0;
    m_next_word = 1'b0;
    m_is_idle   = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // From ACTIVE: owner drops -> DRAIN -> IDLE with the adapter idle.
  task automatic finish_xfer();
    clear_reqs();
    m_next_word = 1'b0;
    m_is_idle   = 1'b1;
    step();
    step();
  endtask

  int pulses;
  int stray;

  initial begin
    // ---- 1: reset state and single port0 read burst
    do_reset();
    #1;
    chk("rst_do_read",   m_do_read,   0);
    chk("rst_do_write",  m_do_write,  0);
    chk("rst_next_word", s_next_word, 0);
    chk("rst_is_idle",   s_is_idle,   3'b111);
    chk("rst_addr",      m_addr,      0);
    set_rd(0, 1'b1, 25'h000100);
    #1;
    chk("t1_no_grant_yet", m_do_read, 0);
    chk("t1_req_not_idle", s_is_idle, 3'b110);
    step(); #1;
    chk("t1_grant_rd", m_do_read, 1);
    chk("t1_addr",     m_addr,    25'h000100);
    m_is_idle = 1'b0;
    pulses = 0;
    stray  = 0;
    for (int k = 0; k < 6; k++) begin
      m_next_word = (k != 2) && (k != 5);
      m_rdata     = 32'hA000 + k;
      #1;
      if (s_next_word[0]) pulses++;
      if (s_next_word[1] || s_next_word[2]) stray++;
      if (k == 3) chk("t1_rdata", s_rdata, 32'hA003);
      step();
    end
    chk("t1_pulses",   pulses, 4);
    chk("t1_nw_other", stray,  0);
    m_next_word = 1'b0;
    set_rd(0, 1'b0, '0);
    #1;
    chk("t1_drop_rd", m_do_read, 0);
    step(); #1;
    chk("t1_drain_busy", s_is_idle, 3'b110);
    m_is_idle = 1'b1;
    step(); #1;
    chk("t1_back_idle", s_is_idle, 3'b111);

    // ---- 2: simultaneous requests from reset
    do_reset();
    set_rd(0, 1'b1, 25'h10);
    set_rd(1, 1'b1, 25'h20);
    step(); #1;
    chk("t2_first_p0", m_addr,    25'h10);
    chk("t2_p1_waits", s_is_idle, 3'b100);
    m_is_idle = 1'b0;
    step();
    set_rd(0, 1'b0, '0);
    step(); #1;
    chk("t2_drain_do",   m_do_read, 0);
    chk("t2_drain_addr", m_addr,    0);
    m_is_idle = 1'b1;
    step(); #1;
    chk("t2_idle_gap", m_do_read, 0);
    step(); #1;
    chk("t2_p1_rd",   m_do_read, 1);
    chk("t2_p1_addr", m_addr,    25'h20);
    finish_xfer();
    set_rd(0, 1'b1, 25'h30);
    step();
    finish_xfer();
    set_rd(0, 1'b1, 25'h40);
    set_rd(1, 1'b1, 25'h50);
    step(); #1;
`ifdef QPI_ARB_PRIO_EN
    chk("t2_pair_second", m_addr, 25'h40);
`else
    chk("t2_pair_second", m_addr, 25'h50);
`endif
    finish_xfer();

    // ---- 3: port1 write while port0 raises a read
    set_wr(1, 1'b1, 25'h55, 32'hDEADBEEF);
    step(); #1;
    chk("t3_wr_grant", m_do_write, 1);
    chk("t3_wdata",    m_wdata,    32'hDEADBEEF);
    m_is_idle   = 1'b0;
    m_next_word = 1'b1;
    set_rd(0, 1'b1, 25'h66);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_wdata_hold", m_wdata,     32'hDEADBEEF);
      chk("t3_p0_busy",    s_is_idle,   3'b100);
      chk("t3_nw_owner",   s_next_word, 3'b010);
      step();
    end
    set_wr(1, 1'b0, '0, '0);
    m_next_word = 1'b0;
    step(); #1;
    chk("t3_drain_rd", m_do_read, 0);
    chk("t3_drain_wd", m_wdata,   0);
    step(); #1;
    chk("t3_wait_idle", m_do_read, 0);
    m_is_idle = 1'b1;
    step(); #1;
    chk("t3_idle_gap", m_do_read, 0);
    step(); #1;
    chk("t3_p0_grant", m_do_read, 1);
    chk("t3_p0_addr",  m_addr,    25'h66);
    finish_xfer();

    // ---- 5: reset during an active read
    set_rd(1, 1'b1, 25'h88);
    step(); #1;
    chk("t5_active", m_do_read, 1);
    m_next_word = 1'b1;
    #1;
    chk("t5_nw_pre", s_next_word, 3'b010);
    rst_n = 1'b0;
    step(); #1;
    chk("t5_rst_rd",   m_do_read,   0);
    chk("t5_rst_nw",   s_next_word, 0);
    chk("t5_rst_idle", s_is_idle,   3'b101);
    rst_n       = 1'b1;
    m_next_word = 1'b0;
    clear_reqs();
    step();
    set_rd(0, 1'b1, 25'hB0);
    set_rd(2, 1'b1, 25'hB2);
    #1;
    chk("t5_no_grant_yet", m_do_read, 0);
    step(); #1;
    chk("t5_first_after_rst", m_addr, 25'hB0);
    finish_xfer();

    // ---- 4: long drain
    set_rd(2, 1'b1, 25'h77);
    step(); #1;
    chk("t4_p2_addr", m_addr, 25'h77);
    m_is_idle = 1'b0;
    set_rd(2, 1'b0, '0);
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_drain_rd",   m_do_read, 0);
      chk("t4_drain_busy", s_is_idle, 3'b011);
      if (k == 4) m_is_idle = 1'b1;
      step();
    end
    #1;
    chk("t4_idle", s_is_idle, 3'b111);

    // ---- 6: port1 busy, port0 and port2 wait for the gap
    set_rd(1, 1'b1, 25'hA1);
    step(); #1;
    chk("t6_p1_addr", m_addr, 25'hA1);
    m_is_idle = 1'b0;
    set_rd(0, 1'b1, 25'hA0);
    set_rd(2, 1'b1, 25'hA2);
    step(); #1;
    chk("t6_no_preempt", m_addr,    25'hA1);
    chk("t6_all_busy",   s_is_idle, 3'b000);
    set_rd(1, 1'b0, '0);
    step();
    m_is_idle = 1'b1;
    step();
    step(); #1;
`ifdef QPI_ARB_PRIO_EN
    chk("t6_gap_winner", m_addr, 25'hA0);
`else
    chk("t6_gap_winner", m_addr, 25'hA2);
`endif
    finish_xfer();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
